// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone register slave with a prescaled 16-bit timer.
// Register map (word addresses): 0 CTRL {IRQEN,AUTORELOAD,EN}, 1 PRESCALE,
// 2 COUNT, 3 COMPARE, 4 STATUS {MATCH, write-1-to-clear}, 5-7 read as zero.
// Bus transfers take WAIT_STATES idle cycles, then a single-cycle ack; writes
// land on the edge that ends the ack cycle.
module wb_timer_slave #(
    parameter int          WAIT_STATES    = 1,
    parameter logic [15:0] RESET_PRESCALE = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t      state;
    logic [3:0]  wcnt;
    logic [2:0]  adr_q;
    logic        we_q;
    logic [15:0] dat_q;

    logic [2:0]  ctrl;
    logic [15:0] prescale, count, compare, psc;
    logic        match;

    logic [2:0]  ctrl_n;
    logic [15:0] prescale_n, count_n, compare_n, psc_n;
    logic        match_n;
    logic        wr, tick, hit;
    logic [2:0]  rd_adr;
    logic [15:0] rd_data;

    // upper address bits are deliberately not decoded
    logic unused_adr;
    assign unused_adr = ^adr_i[15:3];

    // Next-state of every register; read data is taken from the next state so
    // dat_o shows the value the register holds during the ack cycle.
    always_comb begin
        wr         = (state == S_ACK) && we_q;
        tick       = ctrl[0] && (psc == prescale);
        hit        = tick && (count == compare);

        ctrl_n     = ctrl;
        prescale_n = prescale;
        compare_n  = compare;
        if (wr && adr_q == 3'd0) ctrl_n     = dat_q[2:0];
        if (wr && adr_q == 3'd1) prescale_n = dat_q;
        if (wr && adr_q == 3'd3) compare_n  = dat_q;

        // prescaler held at 0 while disabled, restarts on a PRESCALE write
        psc_n = (!ctrl[0] || tick) ? 16'h0000 : psc + 16'h0001;
        if (wr && adr_q == 3'd1) psc_n = 16'h0000;

        // bus write to COUNT wins over the tick update
        count_n = count;
        if (wr && adr_q == 3'd2)
            count_n = dat_q;
        else if (tick)
            count_n = (hit && ctrl[1]) ? 16'h0000 : count + 16'h0001;

        // a new match wins over a same-cycle clear
        match_n = match;
        if (hit)
            match_n = 1'b1;
        else if (wr && adr_q == 3'd4 && dat_q[0])
            match_n = 1'b0;

        rd_adr = (state == S_IDLE) ? adr_i[2:0] : adr_q;
        case (rd_adr)
            3'd0:    rd_data = {13'h0000, ctrl_n};
            3'd1:    rd_data = prescale_n;
            3'd2:    rd_data = count_n;
            3'd3:    rd_data = compare_n;
            3'd4:    rd_data = {15'h0000, match_n};
            default: rd_data = 16'h0000;
        endcase
    end

    // Bus FSM: accept, optional wait states, one-cycle ack with registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
            adr_q <= 3'd0;
            we_q  <= 1'b0;
            dat_q <= 16'h0000;
            ack_o <= 1'b0;
            dat_o <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    dat_o <= 16'h0000;
                    if (cyc_i && stb_i) begin
                        adr_q <= adr_i[2:0];
                        we_q  <= we_i;
                        dat_q <= dat_i;
                        if (WAIT_STATES == 0) begin
                            state <= S_ACK;
                            ack_o <= 1'b1;
                            dat_o <= we_i ? 16'h0000 : rd_data;
                        end else begin
                            state <= S_WAIT;
                            wcnt  <= WS_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!cyc_i) begin
                        state <= S_IDLE;
                    end else if (wcnt == 4'd0) begin
                        state <= S_ACK;
                        ack_o <= 1'b1;
                        dat_o <= we_q ? 16'h0000 : rd_data;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    ack_o <= 1'b0;
                    dat_o <= 16'h0000;
                end
                default: begin
                    state <= S_IDLE;
                    ack_o <= 1'b0;
                    dat_o <= 16'h0000;
                end
            endcase
        end
    end

    // Timer and register file state; irq follows MATCH & IRQEN one cycle later.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl     <= 3'd0;
            prescale <= RESET_PRESCALE;
            count    <= 16'h0000;
            compare  <= 16'hFFFF;
            match    <= 1'b0;
            psc      <= 16'h0000;
            irq_o    <= 1'b0;
        end else begin
            ctrl     <= ctrl_n;
            prescale <= prescale_n;
            count    <= count_n;
            compare  <= compare_n;
            match    <= match_n;
            psc      <= psc_n;
            irq_o    <= match & ctrl[2];
        end
    end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Bench for wb_timer_slave: the driver steps a behavioural timer model one
// clock at a time and queues the expected ack (data + cycle); a monitor on the
// falling edge matches every ack against the queue and checks irq_o.
module tb_wb_timer_slave;

    localparam int          WS = 1;
    localparam logic [15:0] RP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_i, cyc_i, stb_i, we_i;
    logic [15:0] adr_i, dat_i, dat_o;
    logic        ack_o, irq_o;

    always #5 clk = ~clk;

    wb_timer_slave #(.WAIT_STATES(WS), .RESET_PRESCALE(RP)) dut (
        .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o)
    );

    // reference model
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre, m_cnt, m_cmp;
    logic        m_match, m_irq, m_rst;
    int          m_phase;   // enabled cycles elapsed in the current prescale period

    int tests = 0;
    int fails = 0;
    int tcyc  = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {13'h0000, m_ctrl};
            3'd1:    return m_pre;
            3'd2:    return m_cnt;
            3'd3:    return m_cmp;
            3'd4:    return {15'h0000, m_match};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 3'd0; m_pre = RP; m_cnt = 16'h0000; m_cmp = 16'hFFFF;
        m_match = 1'b0; m_irq = 1'b0; m_phase = 0;
    endtask

    // One clock: the timer ticks once every PRESCALE+1 enabled cycles; a bus
    // write (commit) lands on the same edge.
    task automatic step(input bit commit, input logic [2:0] wa, input logic [15:0] wd);
        bit tick, hit;
        @(posedge clk);
        if (!m_rst) begin
            tick  = m_ctrl[0] && (m_phase == int'(m_pre));
            hit   = tick && (m_cnt == m_cmp);
            m_irq = m_match && m_ctrl[2];
            m_phase = (!m_ctrl[0] || tick) ? 0 : m_phase + 1;
            if (tick) m_cnt = (hit && m_ctrl[1]) ? 16'h0000 : m_cnt + 16'h0001;
            if (hit) m_match = 1'b1;
            if (commit) begin
                case (wa)
                    3'd0: m_ctrl = wd[2:0];
                    3'd1: begin m_pre = wd; m_phase = 0; end
                    3'd2: m_cnt = wd;
                    3'd3: m_cmp = wd;
                    3'd4: if (wd[0] && !hit) m_match = 1'b0;
                    default: ;
                endcase
            end
        end
        tcyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 3'd0, 16'h0000);
    endtask

    task automatic xact(input bit we, input logic [2:0] a, input logic [15:0] d, input bit abort);
        exp_t e;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
        adr_i = {13'($urandom), a};
        dat_i = d;
        step(0, 3'd0, 16'h0000);          // request accepted here
        stb_i = 1'b0;
        if (abort) begin
            cyc_i = 1'b0;
            step(0, 3'd0, 16'h0000);      // wait state sees cyc low
            we_i = 1'b0;
            return;
        end
        repeat (WS) step(0, 3'd0, 16'h0000);
        e.data = we ? 16'h0000 : m_read(a);
        e.cyc  = tcyc;
        sb.push_back(e);
        step(we, a, d);                   // edge ending the ack cycle
        cyc_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        xact(1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a);
        xact(1'b0, a, 16'($urandom), 1'b0);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: every ack must match the head of the scoreboard at the right cycle
    always @(negedge clk) begin
        exp_t e;
        tests++;
        if (irq_o !== m_irq) begin
            fails++;
            $display("FAIL irq: got %b expected %b at cycle %0d", irq_o, m_irq, tcyc);
        end
        if (ack_o === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL ack_extra: got ack with dat_o %h expected no ack at cycle %0d", dat_o, tcyc);
            end else begin
                e = sb.pop_front();
                if (dat_o !== e.data || tcyc != e.cyc) begin
                    fails++;
                    $display("FAIL ack_data: got %h at cycle %0d expected %h at cycle %0d",
                             dat_o, tcyc, e.data, e.cyc);
                end
            end
        end else begin
            tests++;
            if (dat_o !== 16'h0000) begin
                fails++;
                $display("FAIL dat_idle: got %h expected 0000 at cycle %0d", dat_o, tcyc);
            end
            if (sb.size() != 0 && tcyc > sb[0].cyc) begin
                e = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL ack_missing: got no ack expected ack %h at cycle %0d", e.data, e.cyc);
            end
        end
    end

    initial begin
        bit          we;
        logic [2:0]  a;
        logic [15:0] d;

        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        adr_i = 16'h0000; dat_i = 16'h0000;
        m_rst = 1'b1;
        model_reset();
        idle(3);
        chk("reset_ack", {15'h0, ack_o}, 16'h0000);
        chk("reset_dat", dat_o, 16'h0000);
        rst_i = 1'b1; m_rst = 1'b0;
        idle(2);

        // first read after reset: COMPARE = FFFF, ack WS+1 cycles after accept
        rd(3'd3);
        for (int i = 0; i < 8; i++) rd(3'(i));

        // prescale 3, compare 5, enable + autoreload + irq
        wr(3'd1, 16'd3); wr(3'd3, 16'd5); wr(3'd2, 16'd0); wr(3'd0, 16'h0007);
        for (int i = 0; i < 8; i++) begin idle(3); rd(3'd2); end
        rd(3'd4);
        wr(3'd4, 16'h0001);
        idle(2);
        rd(3'd4);

        // wrap: COUNT FFFF -> 0 without match
        wr(3'd0, 16'h0000); wr(3'd4, 16'h0001); wr(3'd1, 16'd0);
        wr(3'd3, 16'h0010); wr(3'd2, 16'hFFFF); wr(3'd0, 16'h0001);
        rd(3'd2); rd(3'd4);

        // collisions: COUNT write on a tick, W1C on a match
        wr(3'd2, 16'h1234);
        rd(3'd2);
        wr(3'd0, 16'h0007); wr(3'd3, 16'h0000); wr(3'd2, 16'h0000);
        idle(2);
        wr(3'd4, 16'h0001);
        rd(3'd4);
        idle(2);

        // abort during wait: COMPARE unchanged
        xact(1'b1, 3'd3, 16'hAAAA, 1'b1);
        rd(3'd3);

        // unmapped address
        wr(3'd6, 16'hBEEF);
        rd(3'd6);
        for (int i = 0; i < 5; i++) rd(3'(i));

        // randomized traffic, timer running
        for (int n = 0; n < 300; n++) begin
            a  = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            case (a)
                3'd1:    d = 16'($urandom_range(0, 3));
                3'd2:    d = 16'($urandom_range(0, 24));
                3'd3:    d = 16'($urandom_range(0, 24));
                default: d = 16'($urandom);
            endcase
            xact(we, a, d, $urandom_range(0, 9) == 0);
            idle($urandom_range(0, 3));
        end

        // reset in the middle of a wait state
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0003; dat_i = 16'h1111;
        step(0, 3'd0, 16'h0000);
        stb_i = 1'b0;
        rst_i = 1'b0; m_rst = 1'b1; model_reset();
        #1;
        chk("rst_wait_ack", {15'h0, ack_o}, 16'h0000);
        chk("rst_wait_irq", {15'h0, irq_o}, 16'h0000);
        idle(2);
        cyc_i = 1'b0; we_i = 1'b0;
        rst_i = 1'b1; m_rst = 1'b0;
        idle(1);
        for (int i = 0; i < 5; i++) rd(3'(i));

        // reset during the ack cycle of a write: no commit
        wr(3'd0, 16'h0001);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0002; dat_i = 16'h5555;
        step(0, 3'd0, 16'h0000);
        stb_i = 1'b0;
        repeat (WS) step(0, 3'd0, 16'h0000);
        rst_i = 1'b0; m_rst = 1'b1; model_reset();
        #1;
        chk("rst_ack_ack", {15'h0, ack_o}, 16'h0000);
        chk("rst_ack_dat", dat_o, 16'h0000);
        cyc_i = 1'b0; we_i = 1'b0;
        idle(1);
        rst_i = 1'b1; m_rst = 1'b0;
        idle(1);
        rd(3'd2); rd(3'd0);

        idle(4);
        chk("sb_empty", 16'(sb.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
